// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_pkg                                                              |
// | Shared types and SPI mode constants for the SPI responder.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    localparam int SPI_CPOL = 0;
    localparam int SPI_CPHA = 0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_sync_edge                                                        |
// | Multi-flop synchronizer with rise/fall pulses for one async input.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Reset value matches the idle level so release never creates an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_dly  <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_slave_rx_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_slave_rx_tx                                                      |
// | Oversampled SPI mode-0 responder with one-word TX buffer.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_10MHz,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_load_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             tx_underrun_o,
    output logic             busy_o
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    logic                   w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic                   w_cs_n_s, w_cs_rise, w_cs_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi_s;
    logic                   w_lead_edge, w_trail_edge, w_sample_edge, w_shift_edge;
    logic                   w_unused_levels;

    spi_slv_state_t      r_state, w_state_nx;
    logic [c_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nx;
    logic [WIDTH-1:0]    r_rx_shift, w_rx_shift_nx;
    logic [WIDTH-1:0]    r_tx_shift, w_tx_shift_nx;
    logic [WIDTH-1:0]    r_tx_buf, w_tx_buf_nx;
    logic                r_tx_ready, w_tx_ready_nx;
    logic [WIDTH-1:0]    r_rx_data, w_rx_data_nx;
    logic                r_rx_valid, w_rx_valid_nx;
    logic                r_underrun, w_underrun_nx;
    logic                r_miso, w_miso_nx;
    logic                r_busy;
    logic                w_consume;
    logic [WIDTH-1:0]    w_tx_word;
    logic [WIDTH-1:0]    w_rx_word;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'(SPI_CPOL))
    ) u_sclk_sync (
        .clk     (clk_10MHz),
        .rst_n   (rst_i),
        .i_async (sclk_i),
        .o_sync  (w_sclk_s),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk     (clk_10MHz),
        .rst_n   (rst_i),
        .i_async (cs_n_i),
        .o_sync  (w_cs_n_s),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // MOSI goes through the same depth as SCLK so data and edge stay aligned.
    always_ff @(posedge clk_10MHz or negedge rst_i) begin
        if (!rst_i) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
        end
    end

    assign w_mosi_s        = r_mosi_sync[SYNC_STAGES-1];
    assign w_unused_levels = w_sclk_s & w_cs_n_s;

    assign w_lead_edge   = (SPI_CPOL == 0) ? w_sclk_rise : w_sclk_fall;
    assign w_trail_edge  = (SPI_CPOL == 0) ? w_sclk_fall : w_sclk_rise;
    assign w_sample_edge = (SPI_CPHA == 0) ? w_lead_edge : w_trail_edge;
    assign w_shift_edge  = (SPI_CPHA == 0) ? w_trail_edge : w_lead_edge;

    assign w_tx_word = r_tx_ready ? '0 : r_tx_buf;
    assign w_rx_word = {r_rx_shift[WIDTH-2:0], w_mosi_s};

    always_ff @(posedge clk_10MHz or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_tx_buf   <= '0;
            r_tx_ready <= 1'b1;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_buf   <= w_tx_buf_nx;
            r_tx_ready <= w_tx_ready_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_underrun <= w_underrun_nx;
            r_miso     <= w_miso_nx;
            r_busy     <= (w_state_nx == ACTIVE);
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_rx_shift_nx = r_rx_shift;
        w_tx_shift_nx = r_tx_shift;
        w_tx_buf_nx   = r_tx_buf;
        w_tx_ready_nx = r_tx_ready;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        w_underrun_nx = 1'b0;
        w_miso_nx     = r_miso;
        w_consume     = 1'b0;

        case (r_state)
            IDLE: begin
                w_miso_nx    = 1'b0;
                w_bit_cnt_nx = '0;
                if (w_cs_fall) begin
                    w_state_nx = ACTIVE;
                    w_consume  = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect wins over a coincident SCLK edge; that bit is dropped.
                if (w_cs_rise) begin
                    w_state_nx   = IDLE;
                    w_bit_cnt_nx = '0;
                    w_miso_nx    = 1'b0;
                end else if (w_sample_edge) begin
                    w_rx_shift_nx = w_rx_word;
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_rx_data_nx  = w_rx_word;
                        w_rx_valid_nx = 1'b1;
                        w_bit_cnt_nx  = '0;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end else if (w_shift_edge) begin
                    if (r_bit_cnt != '0) begin
                        w_tx_shift_nx = {r_tx_shift[WIDTH-2:0], 1'b0};
                        w_miso_nx     = r_tx_shift[WIDTH-2];
                    end else begin
                        w_consume = 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        if (w_consume) begin
            w_tx_shift_nx = w_tx_word;
            w_miso_nx     = w_tx_word[WIDTH-1];
            w_underrun_nx = r_tx_ready;
            // A load landing on the consume cycle refills the buffer at once.
            w_tx_ready_nx = ~tx_load_i;
            if (tx_load_i) begin
                w_tx_buf_nx = tx_data_i;
            end
        end else if (tx_load_i && r_tx_ready) begin
            w_tx_buf_nx   = tx_data_i;
            w_tx_ready_nx = 1'b0;
        end
    end

    assign miso_o        = r_miso;
    assign tx_ready_o    = r_tx_ready;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_underrun_o = r_underrun;
    assign busy_o        = r_busy;

endmodule : spi_slave_rx_tx
`default_nettype wire

// File: tb/tb_spi_slave_rx_tx.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_slave_rx_tx                                                   |
// | Self-checking bench: bit-banged SPI master plus RX scoreboard.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_spi_slave_rx_tx;

    localparam int c_WIDTH = 8;
    localparam int c_SYNC  = 2;
    localparam int c_HALF  = 50;

    logic               clk_10MHz = 1'b0;
    logic               rst_i     = 1'b0;
    logic               sclk_i    = 1'b0;
    logic               cs_n_i    = 1'b1;
    logic               mosi_i    = 1'b0;
    logic               miso_o;
    logic [c_WIDTH-1:0] tx_data_i = '0;
    logic               tx_load_i = 1'b0;
    logic               tx_ready_o;
    logic [c_WIDTH-1:0] rx_data_o;
    logic               rx_valid_o;
    logic               tx_underrun_o;
    logic               busy_o;

    int total = 0;
    int bad   = 0;
    int under_cnt = 0;
    logic [7:0] rx_q[$];

    typedef struct {
        bit         load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        int         exp_under;
    } vec_t;

    vec_t vecs[5];

    spi_slave_rx_tx #(
        .WIDTH       (c_WIDTH),
        .SYNC_STAGES (c_SYNC)
    ) dut (
        .clk_10MHz     (clk_10MHz),
        .rst_i         (rst_i),
        .sclk_i        (sclk_i),
        .cs_n_i        (cs_n_i),
        .mosi_i        (mosi_i),
        .miso_o        (miso_o),
        .tx_data_i     (tx_data_i),
        .tx_load_i     (tx_load_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #50 clk_10MHz = ~clk_10MHz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_10MHz);
    endtask

    task automatic load_pulse(input logic [7:0] d);
        tx_data_i = d;
        tx_load_i = 1'b1;
        wait_clks(1);
        tx_load_i = 1'b0;
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest queued word.
    always @(negedge clk_10MHz) begin
        if (rst_i) begin
            if (rx_valid_o) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected", {24'h0, rx_data_o}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_word", {24'h0, rx_data_o}, {24'h0, rx_q.pop_front()});
                end
            end
            if (tx_underrun_o) under_cnt++;
        end
    end

    // Word k of mo/mi lives at [8k+7:8k]; abort_after>0 deselects after that many rises.
    task automatic spi_frame(
        input  int          nwords,
        input  logic [23:0] mo,
        input  int          abort_after,
        input  bit          mid_en,
        input  logic [7:0]  mid_data,
        input  bit          bnd_en,
        input  logic [7:0]  bnd_data,
        output logic [23:0] mi,
        output logic        rdy_early,
        output logic        rdy_late,
        output logic        bnd_rdy_seen,
        output logic        busy_after
    );
        int nbits;
        nbits        = nwords * 8;
        mi           = '0;
        bnd_rdy_seen = 1'b0;
        busy_after   = 1'b1;
        if (abort_after == 0) begin
            for (int k = 0; k < nwords; k++) rx_q.push_back(mo[k*8 +: 8]);
        end
        cs_n_i = 1'b0;
        mosi_i = mo[7];
        wait_clks(c_SYNC);
        rdy_early = tx_ready_o;
        wait_clks(2);
        rdy_late = tx_ready_o;
        if (mid_en) begin
            load_pulse(mid_data);
            wait_clks(c_HALF - c_SYNC - 3);
        end else begin
            wait_clks(c_HALF - c_SYNC - 2);
        end
        for (int b = 0; b < nbits; b++) begin
            int w  = b / 8;
            int bi = 7 - (b % 8);
            int nb = b + 1;
            sclk_i = 1'b1;
            mi[w*8 + bi] = miso_o;
            wait_clks(c_HALF);
            if (abort_after == b + 1) begin
                sclk_i = 1'b0;
                cs_n_i = 1'b1;
                wait_clks(c_SYNC + 2);
                busy_after = busy_o;
                wait_clks(c_HALF);
                return;
            end
            if (b == nbits - 1) begin
                sclk_i = 1'b0;
                cs_n_i = 1'b1;
                mosi_i = 1'b0;
            end else begin
                sclk_i = 1'b0;
                mosi_i = mo[(nb / 8) * 8 + 7 - (nb % 8)];
                if (bnd_en && b == 7) begin
                    wait_clks(c_SYNC);
                    load_pulse(bnd_data);
                    for (int k = 0; k < 3; k++) begin
                        if (tx_ready_o) bnd_rdy_seen = 1'b1;
                        wait_clks(1);
                    end
                    wait_clks(c_HALF - c_SYNC - 4);
                end else begin
                    wait_clks(c_HALF);
                end
            end
        end
        wait_clks(c_HALF);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] mi;
        logic        re, rl, bs, ba;
        int          u0;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
        vecs[1] = '{1'b0, 8'h00, 8'h55, 8'h00, 1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[3] = '{1'b1, 8'h01, 8'h80, 8'h01, 0};
        vecs[4] = '{1'b1, 8'h96, 8'hE7, 8'h96, 0};

        wait_clks(3);
        check("reset_miso",  {31'h0, miso_o}, 32'd0);
        check("reset_rx",    {24'h0, rx_data_o}, 32'd0);
        check("reset_valid", {31'h0, rx_valid_o}, 32'd0);
        check("reset_under", {31'h0, tx_underrun_o}, 32'd0);
        check("reset_busy",  {31'h0, busy_o}, 32'd0);
        check("reset_ready", {31'h0, tx_ready_o}, 32'd1);
        rst_i = 1'b1;
        wait_clks(5);

        // Single-word frames from the table.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].load) begin
                load_pulse(vecs[i].tx);
                check("ready_after_load", {31'h0, tx_ready_o}, 32'd0);
            end
            u0 = under_cnt;
            spi_frame(1, {16'h0, vecs[i].mosi}, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi, re, rl, bs, ba);
            check("vec_miso", {24'h0, mi[7:0]}, {24'h0, vecs[i].exp_miso});
            check("vec_under", under_cnt - u0, vecs[i].exp_under);
            check("vec_rx_data", {24'h0, rx_data_o}, {24'h0, vecs[i].mosi});
            check("vec_drained", rx_q.size(), 32'd0);
            check("vec_ready_end", {31'h0, tx_ready_o}, 32'd1);
            if (vecs[i].load) begin
                check("vec_ready_early", {31'h0, re}, 32'd0);
                check("vec_ready_late", {31'h0, rl}, 32'd1);
            end
        end

        // Two-word frame with a reload during the first word.
        load_pulse(8'h12);
        u0 = under_cnt;
        spi_frame(2, {8'h00, 8'h0F, 8'hF0}, 0, 1'b1, 8'h34, 1'b0, 8'h00, mi, re, rl, bs, ba);
        check("multi_miso0", {24'h0, mi[7:0]}, 32'h12);
        check("multi_miso1", {24'h0, mi[15:8]}, 32'h34);
        check("multi_under", under_cnt - u0, 32'd0);
        check("multi_drained", rx_q.size(), 32'd0);
        check("multi_rx_last", {24'h0, rx_data_o}, 32'h0F);

        // Abort after 5 rises; the buffer loaded mid-frame must survive.
        u0 = under_cnt;
        spi_frame(1, {16'h0, 8'hAA}, 5, 1'b1, 8'h5A, 1'b0, 8'h00, mi, re, rl, bs, ba);
        check("abort_busy", {31'h0, ba}, 32'd0);
        check("abort_under", under_cnt - u0, 32'd1);
        check("abort_rx_kept", {24'h0, rx_data_o}, 32'h0F);
        check("abort_buf_kept", {31'h0, tx_ready_o}, 32'd0);
        u0 = under_cnt;
        spi_frame(1, {16'h0, 8'h81}, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi, re, rl, bs, ba);
        check("post_abort_miso", {24'h0, mi[7:0]}, 32'h5A);
        check("post_abort_under", under_cnt - u0, 32'd0);
        check("post_abort_rx", {24'h0, rx_data_o}, 32'h81);
        check("post_abort_drained", rx_q.size(), 32'd0);

        // Asynchronous reset in the middle of bit 3.
        load_pulse(8'h77);
        cs_n_i = 1'b0;
        mosi_i = 1'b1;
        wait_clks(c_HALF);
        for (int k = 0; k < 3; k++) begin
            sclk_i = 1'b1;
            wait_clks(c_HALF);
            sclk_i = 1'b0;
            wait_clks(c_HALF);
        end
        sclk_i = 1'b1;
        wait_clks(20);
        check("pre_reset_busy", {31'h0, busy_o}, 32'd1);
        check("pre_reset_miso", {31'h0, miso_o}, 32'd1);
        #7;
        rst_i  = 1'b0;
        sclk_i = 1'b0;
        cs_n_i = 1'b1;
        mosi_i = 1'b0;
        #1;
        check("async_miso",  {31'h0, miso_o}, 32'd0);
        check("async_busy",  {31'h0, busy_o}, 32'd0);
        check("async_rx",    {24'h0, rx_data_o}, 32'd0);
        check("async_valid", {31'h0, rx_valid_o}, 32'd0);
        check("async_under", {31'h0, tx_underrun_o}, 32'd0);
        check("async_ready", {31'h0, tx_ready_o}, 32'd1);
        wait_clks(3);
        rst_i = 1'b1;
        wait_clks(5);
        check("post_reset_busy", {31'h0, busy_o}, 32'd0);
        u0 = under_cnt;
        spi_frame(1, {16'h0, 8'hC3}, 0, 1'b0, 8'h00, 1'b0, 8'h00, mi, re, rl, bs, ba);
        check("post_reset_rx", {24'h0, rx_data_o}, 32'hC3);
        check("post_reset_miso", {24'h0, mi[7:0]}, 32'h00);
        check("post_reset_under", under_cnt - u0, 32'd1);
        check("post_reset_drained", rx_q.size(), 32'd0);

        // Load while full is dropped; load on the consume cycle is kept.
        load_pulse(8'h11);
        load_pulse(8'h22);
        check("full_ignore_ready", {31'h0, tx_ready_o}, 32'd0);
        u0 = under_cnt;
        spi_frame(3, {8'hA1, 8'hB2, 8'hC3}, 0, 1'b1, 8'h33, 1'b1, 8'h44, mi, re, rl, bs, ba);
        check("bnd_miso0", {24'h0, mi[7:0]}, 32'h11);
        check("bnd_miso1", {24'h0, mi[15:8]}, 32'h33);
        check("bnd_miso2", {24'h0, mi[23:16]}, 32'h44);
        check("bnd_ready_held", {31'h0, bs}, 32'd0);
        check("bnd_under", under_cnt - u0, 32'd0);
        check("bnd_drained", rx_q.size(), 32'd0);
        check("bnd_rx_last", {24'h0, rx_data_o}, 32'hA1);
        check("bnd_ready_end", {31'h0, tx_ready_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_slave_rx_tx
`default_nettype wire
